sort_pass_ctrl: RTL and testbench
=================================

Name: sort_pass_ctrl

Overview:
- Sequences the accel_sort engine across a multi-pass job: latches the job configuration, and drives the engine's key-index, compare-mode and zero-key controls.
- Gates the upstream PLB fetch/store path per pass, counts engine pops and pushes, and signals pass/job completion.
- Sits between the PLB slave register file and the accel_sort instance; one controller per engine.

Parameters:
- INDEX_W, 19, width of start_index to the keygen.
- CNT_W, 20, width of per-pass 64-bit word counters.
- PASS_W, 8, width of pass count/index.
- GAP_CYCLES, 4, idle cycles between passes; must be ≥1. Lets engine output FIFO drain its handshake.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- cmd_start  in  1  one-cycle job start pulse
- cmd_abort  in  1  one-cycle abort pulse
- cfg_words  in  CNT_W  64-bit words per pass; nonzero, multiple of 4
- cfg_passes  in  PASS_W  number of passes; nonzero
- cfg_start_index  in  INDEX_W  keystream start index
- cfg_encrypt_last  in  1  final pass runs with compare disabled
- cfg_zero_key  in  1  job uses zero key
- eng_pop  in  1  engine pop (one 64-bit word consumed)
- eng_push  in  1  engine push (one 64-bit word produced)
- start_index  out  INDEX_W  to engine
- reset_index  out  1  to engine, one-cycle pulse per pass
- no_compare  out  1  to engine
- zero_key  out  1  to engine
- src_en  out  1  upstream fetch enable
- sink_en  out  1  downstream store enable
- pass_idx  out  PASS_W  current pass, 0-based
- busy  out  1  job in progress
- pass_done  out  1  one-cycle pulse at end of each pass
- job_done  out  1  one-cycle pulse at end of job
- cfg_err  out  1  one-cycle pulse: start rejected
- ovf_err  out  1  sticky: pop or push beyond cfg_words; cleared by next accepted start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Configuration is latched only on an accepted cmd_start. The cfg_* inputs are don't-care otherwise.
- start_index and zero_key are driven from latched values and are held through DONE.
- States:
  - IDLE
  - LOAD: reset_index=1 for exactly 1 cycle.
  - RUN
  - DRAIN
  - GAP
  - DONE
- IDLE:
  - cmd_start with cfg_words==0, cfg_words[1:0]!=0, or cfg_passes==0: cfg_err pulses the next cycle and the block stays in IDLE.
  - cmd_start otherwise: latch config, pass_idx=0, clear ovf_err, busy=1, go to LOAD.
- LOAD:
  - no_compare=1 iff cfg_encrypt_last && pass_idx==passes-1; held constant until the pass leaves DRAIN.
  - Clear pop_cnt and push_cnt; next cycle go to RUN.
- RUN:
  - src_en=1 while pop_cnt<cfg_words. sink_en=1.
  - Each eng_pop increments pop_cnt; each eng_push increments push_cnt. Simultaneous pop and push both count in the same cycle.
  - When pop_cnt reaches cfg_words, src_en drops in the following cycle; go to DRAIN.
- DRAIN:
  - src_en=0, sink_en=1.
  - Leave when push_cnt==cfg_words, including when the final push lands in the same cycle as the final pop.
  - On leaving: pass_done pulses 1 cycle. If pass_idx==passes-1 go to DONE, else go to GAP.
- GAP:
  - src_en=0, sink_en=0; wait GAP_CYCLES; then pass_idx++ and go to LOAD.
- DONE:
  - job_done pulses 1 cycle, busy=0, go to IDLE.
- Overflow: eng_pop while pop_cnt==cfg_words, or eng_push while push_cnt==cfg_words, sets ovf_err. The counters saturate and the FSM continues.
- Events outside a job: eng_pop/eng_push seen in IDLE set ovf_err.
- cmd_start while busy: ignored, no cfg_err.
- cmd_abort, any state except IDLE:
  - Next cycle: state IDLE, busy=0, src_en=0, sink_en=0, no_compare=0.
  - No pass_done or job_done pulse; reset_index pulses once to rewind the keystream.
- cmd_abort and cmd_start in the same cycle: abort wins; the start is dropped.
- Latencies:
  - cmd_start to reset_index: 1 cycle.
  - reset_index to src_en: 1 cycle.
  - Final push to pass_done: 1 cycle.

Test Plan:
- words=8, passes=1, encrypt_last=0; 8 pops then 8 pushes → reset_index 1 cycle after start; src_en drops after 8th pop; pass_done then job_done; no_compare=0 throughout.
- words=4, passes=3, encrypt_last=1 → 3 reset_index pulses spaced by GAP_CYCLES; pass_idx 0,1,2; no_compare=1 only in pass 2; 3 pass_done pulses, 1 job_done.
- Start with words=6, words=0, or passes=0 → cfg_err pulse; busy stays 0; no reset_index.
- words=4: pop 4 and push 4 with the 4th push coinciding with the 4th pop → DRAIN exits immediately; pass_done fires; ovf_err=0.
- words=4: a 5th pop arrives in DRAIN → ovf_err=1 and stays set; job completes normally; next valid start clears it.
- Abort mid-RUN after 2 pops → busy=0 and src_en=0 next cycle; one reset_index pulse; no done pulses. Same-cycle start+abort while IDLE → nothing starts.

Source files
------------

// File: rtl/sort_pass_ctrl.sv
// Multi-pass sequencer for one accel_sort engine: latches the job configuration,
// gates the upstream fetch/store path per pass and counts engine pops/pushes.
module sort_pass_ctrl #(
    parameter int INDEX_W    = 19,
    parameter int CNT_W      = 20,
    parameter int PASS_W     = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [CNT_W-1:0]   cfg_words,
    input  logic [PASS_W-1:0]  cfg_passes,
    input  logic [INDEX_W-1:0] cfg_start_index,
    input  logic               cfg_encrypt_last,
    input  logic               cfg_zero_key,
    input  logic               eng_pop,
    input  logic               eng_push,
    output logic [INDEX_W-1:0] start_index,
    output logic               reset_index,
    output logic               no_compare,
    output logic               zero_key,
    output logic               src_en,
    output logic               sink_en,
    output logic [PASS_W-1:0]  pass_idx,
    output logic               busy,
    output logic               pass_done,
    output logic               job_done,
    output logic               cfg_err,
    output logic               ovf_err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_GAP, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [PASS_W-1:0]  passes_q, passes_d;
    logic [INDEX_W-1:0] start_index_q, start_index_d;
    logic               enc_last_q, enc_last_d;
    logic               zero_key_q, zero_key_d;
    logic [PASS_W-1:0]  pass_idx_q, pass_idx_d;
    logic [CNT_W-1:0]   pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               ovf_err_q, ovf_err_d;
    logic               cfg_err_q, cfg_err_d;
    logic               pass_done_q, pass_done_d;
    logic               reset_index_q, reset_index_d;

    logic last_pass;
    logic counting;
    logic bad_cfg;
    logic pass_end;

    assign last_pass = (pass_idx_q == passes_q - PASS_W'(1));
    assign counting  = (state_q == S_RUN) || (state_q == S_DRAIN) ||
                       (state_q == S_GAP) || (state_q == S_DONE);
    assign bad_cfg   = (cfg_words == '0) || (cfg_words[1:0] != 2'b00) || (cfg_passes == '0);

    always_comb begin
        state_d       = state_q;
        words_d       = words_q;
        passes_d      = passes_q;
        start_index_d = start_index_q;
        enc_last_d    = enc_last_q;
        zero_key_d    = zero_key_q;
        pass_idx_d    = pass_idx_q;
        pop_cnt_d     = pop_cnt_q;
        push_cnt_d    = push_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        ovf_err_d     = ovf_err_q;
        cfg_err_d     = 1'b0;
        pass_done_d   = 1'b0;
        reset_index_d = 1'b0;
        pass_end      = 1'b0;

        // Counters saturate at the pass length; any extra word is an overflow.
        if (state_q == S_IDLE && (eng_pop || eng_push)) begin
            ovf_err_d = 1'b1;
        end
        if (counting) begin
            if (eng_pop) begin
                if (pop_cnt_q == words_q) ovf_err_d = 1'b1;
                else                      pop_cnt_d = pop_cnt_q + CNT_W'(1);
            end
            if (eng_push) begin
                if (push_cnt_q == words_q) ovf_err_d  = 1'b1;
                else                       push_cnt_d = push_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        words_d       = cfg_words;
                        passes_d      = cfg_passes;
                        start_index_d = cfg_start_index;
                        enc_last_d    = cfg_encrypt_last;
                        zero_key_d    = cfg_zero_key;
                        pass_idx_d    = '0;
                        ovf_err_d     = 1'b0;
                        reset_index_d = 1'b1;
                        state_d       = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                pop_cnt_d  = '0;
                push_cnt_d = '0;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (pop_cnt_d == words_q) begin
                    if (push_cnt_d == words_q) pass_end = 1'b1;
                    else                       state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (push_cnt_d == words_q) pass_end = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d     = '0;
                    pass_idx_d    = pass_idx_q + PASS_W'(1);
                    reset_index_d = 1'b1;
                    state_d       = S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pass_end) begin
            pass_done_d = 1'b1;
            gap_cnt_d   = '0;
            state_d     = last_pass ? S_DONE : S_GAP;
        end

        // Abort rewinds the keystream and drops the job without done pulses.
        if (cmd_abort && state_q != S_IDLE) begin
            state_d       = S_IDLE;
            reset_index_d = 1'b1;
            pass_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            words_q       <= '0;
            passes_q      <= '0;
            start_index_q <= '0;
            enc_last_q    <= 1'b0;
            zero_key_q    <= 1'b0;
            pass_idx_q    <= '0;
            pop_cnt_q     <= '0;
            push_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            ovf_err_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            pass_done_q   <= 1'b0;
            reset_index_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_q       <= words_d;
            passes_q      <= passes_d;
            start_index_q <= start_index_d;
            enc_last_q    <= enc_last_d;
            zero_key_q    <= zero_key_d;
            pass_idx_q    <= pass_idx_d;
            pop_cnt_q     <= pop_cnt_d;
            push_cnt_q    <= push_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            ovf_err_q     <= ovf_err_d;
            cfg_err_q     <= cfg_err_d;
            pass_done_q   <= pass_done_d;
            reset_index_q <= reset_index_d;
        end
    end

    assign start_index = start_index_q;
    assign zero_key    = zero_key_q;
    assign reset_index = reset_index_q;
    assign pass_idx    = pass_idx_q;
    assign cfg_err     = cfg_err_q;
    assign ovf_err     = ovf_err_q;
    assign pass_done   = pass_done_q;
    assign job_done    = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign src_en      = (state_q == S_RUN) && (pop_cnt_q < words_q);
    assign sink_en     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign no_compare  = enc_last_q && last_pass &&
                         ((state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN));

endmodule

// File: tb/tb_sort_pass_ctrl.sv
// Directed self-checking bench for sort_pass_ctrl: single and multi-pass jobs,
// rejected configurations, coincident final pop/push, overflow and abort.
module tb_sort_pass_ctrl;

    localparam int INDEX_W = 19;
    localparam int CNT_W   = 20;
    localparam int PASS_W  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_start, cmd_abort;
    logic [CNT_W-1:0]   cfg_words;
    logic [PASS_W-1:0]  cfg_passes;
    logic [INDEX_W-1:0] cfg_start_index;
    logic               cfg_encrypt_last, cfg_zero_key;
    logic               eng_pop, eng_push;
    logic [INDEX_W-1:0] start_index;
    logic               reset_index, no_compare, zero_key, src_en, sink_en;
    logic [PASS_W-1:0]  pass_idx;
    logic               busy, pass_done, job_done, cfg_err, ovf_err;

    int n_checks = 0;
    int n_fail   = 0;

    sort_pass_ctrl #(.INDEX_W(INDEX_W), .CNT_W(CNT_W), .PASS_W(PASS_W), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_words(cfg_words), .cfg_passes(cfg_passes), .cfg_start_index(cfg_start_index),
        .cfg_encrypt_last(cfg_encrypt_last), .cfg_zero_key(cfg_zero_key),
        .eng_pop(eng_pop), .eng_push(eng_push), .start_index(start_index),
        .reset_index(reset_index), .no_compare(no_compare), .zero_key(zero_key),
        .src_en(src_en), .sink_en(sink_en), .pass_idx(pass_idx), .busy(busy),
        .pass_done(pass_done), .job_done(job_done), .cfg_err(cfg_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic start, input logic abort, input logic pop, input logic push);
        cmd_start = start;
        cmd_abort = abort;
        eng_pop   = pop;
        eng_push  = push;
    endtask

    task automatic set_cfg(input int words, input int passes, input logic enc_last);
        cfg_words        = CNT_W'(words);
        cfg_passes       = PASS_W'(passes);
        cfg_encrypt_last = enc_last;
    endtask

    task automatic do_pops(input int n, input logic exp_nc);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(0, 0, 1, 0);
            check_output("run_src_en", src_en, 1);
            check_output("run_no_compare", no_compare, exp_nc);
            tick();
        end
        apply_stimulus(0, 0, 0, 0);
    endtask

    task automatic do_pushes(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(0, 0, 0, 1);
            check_output("drain_src_en", src_en, 0);
            check_output("drain_sink_en", sink_en, 1);
            tick();
        end
        apply_stimulus(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0);
        set_cfg(0, 0, 0);
        cfg_start_index = '0;
        cfg_zero_key    = 1'b0;
        repeat (3) tick();
        check_output("rst_busy", busy, 0);
        check_output("rst_src_en", src_en, 0);
        check_output("rst_sink_en", sink_en, 0);
        check_output("rst_reset_index", reset_index, 0);
        check_output("rst_ovf_err", ovf_err, 0);
        check_output("rst_start_index", start_index, 0);
        reset = 1'b0;
        tick();

        $display("[TB] single pass, 8 words");
        set_cfg(8, 1, 0);
        cfg_start_index = 19'h1_2345;
        cfg_zero_key    = 1'b1;
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t1_load_reset_index", reset_index, 1);
        check_output("t1_load_busy", busy, 1);
        check_output("t1_load_src_en", src_en, 0);
        check_output("t1_start_index", start_index, 32'h1_2345);
        check_output("t1_zero_key", zero_key, 1);
        tick();
        check_output("t1_run_reset_index", reset_index, 0);
        do_pops(8, 0);
        do_pushes(8);
        check_output("t1_pass_done", pass_done, 1);
        check_output("t1_job_done", job_done, 1);
        check_output("t1_done_busy", busy, 0);
        check_output("t1_no_compare", no_compare, 0);
        tick();
        check_output("t1_pass_done_low", pass_done, 0);
        check_output("t1_job_done_low", job_done, 0);
        check_output("t1_ovf_err", ovf_err, 0);
        check_output("t1_held_index", start_index, 32'h1_2345);

        $display("[TB] three passes, encrypt_last");
        set_cfg(4, 3, 1);
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            check_output("t2_load_reset_index", reset_index, 1);
            check_output("t2_pass_idx", pass_idx, p);
            check_output("t2_load_no_compare", no_compare, (p == 2) ? 1 : 0);
            tick();
            check_output("t2_run_reset_index", reset_index, 0);
            do_pops(4, (p == 2) ? 1'b1 : 1'b0);
            do_pushes(4);
            check_output("t2_pass_done", pass_done, 1);
            check_output("t2_job_done", job_done, (p == 2) ? 1 : 0);
            if (p < 2) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    check_output("t2_gap_reset_index", reset_index, 0);
                    check_output("t2_gap_sink_en", sink_en, 0);
                    check_output("t2_gap_busy", busy, 1);
                    check_output("t2_gap_pass_done", pass_done, 0);
                end
                tick();
            end
        end
        tick();
        check_output("t2_idle_busy", busy, 0);
        check_output("t2_idle_job_done", job_done, 0);

        $display("[TB] rejected configurations");
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      set_cfg(6, 1, 0);
            else if (k == 1) set_cfg(0, 1, 0);
            else             set_cfg(4, 0, 0);
            apply_stimulus(1, 0, 0, 0);
            tick();
            apply_stimulus(0, 0, 0, 0);
            check_output("t3_cfg_err", cfg_err, 1);
            check_output("t3_busy", busy, 0);
            check_output("t3_reset_index", reset_index, 0);
            tick();
            check_output("t3_cfg_err_low", cfg_err, 0);
            check_output("t3_busy_after", busy, 0);
        end

        $display("[TB] final pop and push coincide");
        set_cfg(4, 1, 0);
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 1, 1);
            check_output("t4_src_en", src_en, 1);
            tick();
        end
        apply_stimulus(0, 0, 0, 0);
        check_output("t4_pass_done", pass_done, 1);
        check_output("t4_job_done", job_done, 1);
        check_output("t4_ovf_err", ovf_err, 0);
        tick();

        $display("[TB] extra pop in drain");
        set_cfg(4, 1, 0);
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        tick();
        do_pops(4, 0);
        apply_stimulus(0, 0, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t5_ovf_set", ovf_err, 1);
        do_pushes(4);
        check_output("t5_pass_done", pass_done, 1);
        check_output("t5_job_done", job_done, 1);
        check_output("t5_ovf_sticky", ovf_err, 1);
        tick();
        check_output("t5_ovf_idle", ovf_err, 1);

        $display("[TB] abort mid-run");
        set_cfg(8, 2, 0);
        apply_stimulus(1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t6_ovf_cleared", ovf_err, 0);
        tick();
        do_pops(2, 0);
        apply_stimulus(0, 1, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t6_busy", busy, 0);
        check_output("t6_src_en", src_en, 0);
        check_output("t6_sink_en", sink_en, 0);
        check_output("t6_reset_index", reset_index, 1);
        check_output("t6_pass_done", pass_done, 0);
        check_output("t6_job_done", job_done, 0);
        tick();
        check_output("t6_reset_index_low", reset_index, 0);
        check_output("t6_pass_done_later", pass_done, 0);
        check_output("t6_job_done_later", job_done, 0);

        $display("[TB] start and abort together in idle");
        set_cfg(4, 1, 0);
        apply_stimulus(1, 1, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t7_reset_index", reset_index, 0);
        check_output("t7_cfg_err", cfg_err, 0);
        tick();
        check_output("t7_busy", busy, 0);

        $display("[TB] pop while idle");
        check_output("t8_ovf_before", ovf_err, 0);
        apply_stimulus(0, 0, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 0);
        check_output("t8_ovf_idle_pop", ovf_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
